// File: rtl/result_unfold_pkg.sv
// result_unfold_pkg: shared constants and types for the result unfold block.
//   FRAC_W_DEF / DIGITS_DEF : default magnitude fraction width and decimal digit count
//   state_t / ST_*          : controller state encoding
//   bcd_t                   : one BCD nibble
//   TEN                     : decimal radix used by the digit extraction step
package result_unfold_pkg;

    localparam int FRAC_W_DEF = 16;
    localparam int DIGITS_DEF = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_CONV_COS = 2'd1;
    localparam state_t ST_CONV_SIN = 2'd2;
    localparam state_t ST_DONE     = 2'd3;

    typedef logic [3:0] bcd_t;
    localparam bcd_t TEN = 4'd10;

endpackage

// File: rtl/result_unfold_frac_bcd_step.sv
// frac_bcd_step: one fractional decimal digit extraction step.
//   rem      in  FRAC_W  fraction remainder (value = rem / 2^FRAC_W)
//   digit    out 4       next BCD digit, floor(rem * 10 / 2^FRAC_W), always 0..9
//   next_rem out FRAC_W  fraction left over after removing the digit
module frac_bcd_step
    import result_unfold_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic [FRAC_W-1:0] rem,
    output bcd_t              digit,
    output logic [FRAC_W-1:0] next_rem
);

    logic [FRAC_W+3:0] p;

    // rem < 2^FRAC_W, so the product stays below 10 * 2^FRAC_W and the top nibble is 0..9.
    assign p        = {4'b0000, rem} * {{FRAC_W{1'b0}}, TEN};
    assign digit    = p[FRAC_W+3:FRAC_W];
    assign next_rem = p[FRAC_W-1:0];

endmodule

// File: rtl/result_unfold.sv
// result_unfold: restores full-circle signed cos/sin results from first-quadrant magnitudes
// and converts each to sign, integer digit and DIGITS truncated fractional BCD digits.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : result handshake, accepted only while idle
//   cos_mag, sin_mag      : unsigned magnitudes, value = mag / 2^FRAC_W
//   cos_sign, sin_sign    : result signs, 1 = negative
//   c_s_swap              : exchange magnitudes before signing
//   out_valid             : one-cycle pulse when every result output updates
//   cos_val, sin_val      : signed two's-complement results
//   cos_neg/int/frac, sin_neg/int/frac : display sign, BCD integer digit, BCD fraction
// Optional macro RESULT_NEG_ZERO_CLR_EN: clear *_neg when all displayed digits are zero.
module result_unfold
    import result_unfold_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FRAC_W:0]     cos_mag,
    input  logic [FRAC_W:0]     sin_mag,
    input  logic                cos_sign,
    input  logic                sin_sign,
    input  logic                c_s_swap,
    output logic                out_valid,
    output logic [FRAC_W+1:0]   cos_val,
    output logic [FRAC_W+1:0]   sin_val,
    output logic                cos_neg,
    output logic                sin_neg,
    output logic [3:0]          cos_int,
    output logic [3:0]          sin_int,
    output logic [4*DIGITS-1:0] cos_frac,
    output logic [4*DIGITS-1:0] sin_frac
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);
    localparam logic [FRAC_W:0]  ONE  = {1'b1, {FRAC_W{1'b0}}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAC_W:0]     cos_mag_q, sin_mag_q;
    logic                cos_sign_q, sin_sign_q;
    logic [FRAC_W-1:0]   cos_rem_q, sin_rem_q;
    logic [4*DIGITS-1:0] cos_sr_q, sin_sr_q;

    logic                accept, last_step, load;
    logic [FRAC_W:0]     cos_sat, sin_sat, cap_cos, cap_sin;
    logic [FRAC_W-1:0]   step_rem_in, step_rem;
    bcd_t                step_digit;
    logic [4*DIGITS-1:0] cos_sr_next, sin_sr_next;
    logic [FRAC_W+1:0]   cos_ext, sin_ext;
    logic                cos_neg_d, sin_neg_d;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == LAST);
    // Results are complete as the final sin digit is produced; load so they appear in DONE.
    assign load      = (state_q == ST_CONV_SIN) && last_step;

    assign cos_sat = (cos_mag > ONE) ? ONE : cos_mag;
    assign sin_sat = (sin_mag > ONE) ? ONE : sin_mag;
    assign cap_cos = c_s_swap ? sin_sat : cos_sat;
    assign cap_sin = c_s_swap ? cos_sat : sin_sat;

    // Single digit stage shared by both conversion phases.
    assign step_rem_in = (state_q == ST_CONV_SIN) ? sin_rem_q : cos_rem_q;

    frac_bcd_step #(
        .FRAC_W (FRAC_W)
    ) u_step (
        .rem      (step_rem_in),
        .digit    (step_digit),
        .next_rem (step_rem)
    );

    generate
        if (DIGITS > 1) begin : g_sr
            assign cos_sr_next = {cos_sr_q[4*DIGITS-5:0], step_digit};
            assign sin_sr_next = {sin_sr_q[4*DIGITS-5:0], step_digit};
        end else begin : g_sr1
            assign cos_sr_next = step_digit;
            assign sin_sr_next = step_digit;
        end
    endgenerate

    assign cos_ext = {1'b0, cos_mag_q};
    assign sin_ext = {1'b0, sin_mag_q};

`ifdef RESULT_NEG_ZERO_CLR_EN
    // Suppress "-0.0000": sign dropped when every displayed digit is zero.
    assign cos_neg_d = cos_sign_q && !(!cos_mag_q[FRAC_W] && (cos_sr_q == '0));
    assign sin_neg_d = sin_sign_q && !(!sin_mag_q[FRAC_W] && (sin_sr_next == '0));
`else
    assign cos_neg_d = cos_sign_q;
    assign sin_neg_d = sin_sign_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CONV_COS;
                    cnt_d   = '0;
                end
            end
            ST_CONV_COS: begin
                if (last_step) begin
                    state_d = ST_CONV_SIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONV_SIN: begin
                if (last_step) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_mag_q  <= '0;
            sin_mag_q  <= '0;
            cos_sign_q <= 1'b0;
            sin_sign_q <= 1'b0;
            cos_rem_q  <= '0;
            sin_rem_q  <= '0;
            cos_sr_q   <= '0;
            sin_sr_q   <= '0;
        end else if (accept) begin
            cos_mag_q  <= cap_cos;
            sin_mag_q  <= cap_sin;
            cos_sign_q <= cos_sign;
            sin_sign_q <= sin_sign;
            cos_rem_q  <= cap_cos[FRAC_W-1:0];
            sin_rem_q  <= cap_sin[FRAC_W-1:0];
            cos_sr_q   <= '0;
            sin_sr_q   <= '0;
        end else if (state_q == ST_CONV_COS) begin
            cos_rem_q <= step_rem;
            cos_sr_q  <= cos_sr_next;
        end else if (state_q == ST_CONV_SIN) begin
            sin_rem_q <= step_rem;
            sin_sr_q  <= sin_sr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            cos_val   <= '0;
            sin_val   <= '0;
            cos_neg   <= 1'b0;
            sin_neg   <= 1'b0;
            cos_int   <= '0;
            sin_int   <= '0;
            cos_frac  <= '0;
            sin_frac  <= '0;
        end else begin
            out_valid <= load;
            if (load) begin
                cos_val  <= cos_sign_q ? -cos_ext : cos_ext;
                sin_val  <= sin_sign_q ? -sin_ext : sin_ext;
                cos_neg  <= cos_neg_d;
                sin_neg  <= sin_neg_d;
                cos_int  <= {3'b000, cos_mag_q[FRAC_W]};
                sin_int  <= {3'b000, sin_mag_q[FRAC_W]};
                cos_frac <= cos_sr_q;
                sin_frac <= sin_sr_next;
            end
        end
    end

endmodule

// File: tb/tb_result_unfold.sv
module tb_result_unfold;

    localparam int FW = 16;
    localparam int DG = 4;
    localparam int LAT = 2 * DG + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [FW:0]     cos_mag = '0, sin_mag = '0;
    logic            cos_sign = 1'b0, sin_sign = 1'b0, c_s_swap = 1'b0;
    logic            out_valid;
    logic [FW+1:0]   cos_val, sin_val;
    logic            cos_neg, sin_neg;
    logic [3:0]      cos_int, sin_int;
    logic [4*DG-1:0] cos_frac, sin_frac;

    int checks = 0;
    int errors = 0;

    result_unfold #(.FRAC_W(FW), .DIGITS(DG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cos_mag   (cos_mag),
        .sin_mag   (sin_mag),
        .cos_sign  (cos_sign),
        .sin_sign  (sin_sign),
        .c_s_swap  (c_s_swap),
        .out_valid (out_valid),
        .cos_val   (cos_val),
        .sin_val   (sin_val),
        .cos_neg   (cos_neg),
        .sin_neg   (sin_neg),
        .cos_int   (cos_int),
        .sin_int   (sin_int),
        .cos_frac  (cos_frac),
        .sin_frac  (sin_frac)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the magnitude, truncated to DG fractional digits.
    function automatic logic [FW:0] sat(input logic [FW:0] m);
        longint v = longint'(m);
        if (v > (longint'(1) << FW)) v = longint'(1) << FW;
        return FW'(0) + (FW+1)'(v);
    endfunction

    function automatic logic [4*DG-1:0] ref_frac(input logic [FW:0] m);
        longint f = longint'(m) % (longint'(1) << FW);
        longint scale = 1;
        longint d;
        logic [4*DG-1:0] r = '0;
        for (int i = 0; i < DG; i++) scale = scale * 10;
        d = (f * scale) / (longint'(1) << FW);
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [FW+1:0] ref_val(input logic [FW:0] m, input logic s);
        longint v = longint'(m);
        if (s) v = -v;
        return (FW+2)'(v);
    endfunction

    function automatic logic ref_neg(input logic [FW:0] m, input logic s);
        logic neg = s;
`ifdef RESULT_NEG_ZERO_CLR_EN
        if ((longint'(m) >> FW) == 0 && ref_frac(m) == '0) neg = 1'b0;
`endif
        return neg;
    endfunction

    // One transaction; optionally pokes in_valid with junk at cycle 3 of the conversion.
    task automatic run_txn(input logic [FW:0] cm, input logic [FW:0] sm, input logic cs,
                           input logic ss, input logic sw, input logic poke);
        logic [FW:0] ec, es;
        int cyc;
        int pulses;
        ec = sw ? sat(sm) : sat(cm);
        es = sw ? sat(cm) : sat(sm);
        @(negedge clk);
        check("ready_before", in_ready, 1'b1);
        in_valid = 1'b1; cos_mag = cm; sin_mag = sm;
        cos_sign = cs; sin_sign = ss; c_s_swap = sw;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (poke && cyc == 3) begin
                check("ready_busy", in_ready, 1'b0);
                in_valid = 1'b1; cos_mag = 17'h0_1234; sin_mag = 17'h0_4321;
                cos_sign = ~cs; sin_sign = ~ss; c_s_swap = ~sw;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", 64'(cyc), 64'(LAT));
        check("out_valid", out_valid, 1'b1);
        check("cos_val", cos_val, ref_val(ec, cs));
        check("sin_val", sin_val, ref_val(es, ss));
        check("cos_neg", cos_neg, ref_neg(ec, cs));
        check("sin_neg", sin_neg, ref_neg(es, ss));
        check("cos_int", cos_int, 4'(ec >> FW));
        check("sin_int", sin_int, 4'(es >> FW));
        check("cos_frac", cos_frac, ref_frac(ec));
        check("sin_frac", sin_frac, ref_frac(es));
        @(negedge clk);
        check("pulse_end", out_valid, 1'b0);
        check("ready_after", in_ready, 1'b1);
        if (poke) begin
            pulses = 0;
            for (int i = 0; i < LAT + 3; i++) begin
                @(negedge clk);
                if (out_valid) pulses++;
            end
            check("extra_pulses", 64'(pulses), 64'd0);
            check("hold_cos_frac", cos_frac, ref_frac(ec));
        end
    endtask

    initial begin
        int pulses;
        #2;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_cos_val", cos_val, 18'h0);
        check("rst_sin_frac", sin_frac, 16'h0);
        check("rst_cos_neg", cos_neg, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(17'h0_8000, 17'h0_8000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(17'h0_DDB4, 17'h0_8000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(17'h0_0000, 17'h1_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_txn(17'h0_0000, 17'h1_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(17'h1_0100, 17'h0_3000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_txn(17'h1_FFFF, 17'h0_0001, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            run_txn(17'($urandom_range(0, 17'h1_FFFF)), 17'($urandom_range(0, 17'h1_FFFF)),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'(n % 5 == 0));
        end

        // Reset in the middle of a conversion.
        @(negedge clk);
        in_valid = 1'b1; cos_mag = 17'h0_DDB4; sin_mag = 17'h0_8000;
        cos_sign = 1'b1; sin_sign = 1'b1; c_s_swap = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_cos_val", cos_val, 18'h0);
        check("mid_rst_sin_val", sin_val, 18'h0);
        check("mid_rst_cos_frac", cos_frac, 16'h0);
        check("mid_rst_sin_int", sin_int, 4'h0);
        check("mid_rst_sin_neg", sin_neg, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mid_rst_no_pulse", 64'(pulses), 64'd0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_cos_neg", cos_neg, 1'b0);

        run_txn(17'h0_5A5A, 17'h0_A5A5, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_unfold.md
Name: result_unfold

Overview:
- Return-path counterpart of the angle-input/quadrant-reduction stage.
- Accepts first-quadrant CORDIC magnitudes (cos, sin) with the sign and swap flags produced by the input stage.
- Restores full-circle signed results and serially converts each to decimal digits (sign, integer digit, fractional digits) for the output display block.
- Sits between the arithmetic block and the result display block.

Parameters:
FRAC_W, 16, fractional bits of the unsigned magnitude inputs (value = mag / 2^FRAC_W).
DIGITS, 4, number of fractional decimal digits produced per result.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  arithmetic result valid.
in_ready  out  1  block idle, can accept a result.
cos_mag  in  FRAC_W+1  unsigned first-quadrant cos magnitude.
sin_mag  in  FRAC_W+1  unsigned first-quadrant sin magnitude.
cos_sign  in  1  final cos sign, 1 = negative.
sin_sign  in  1  final sin sign, 1 = negative.
c_s_swap  in  1  1 = exchange cos/sin magnitudes before signing.
out_valid  out  1  one-cycle pulse, all result outputs updated.
cos_val  out  FRAC_W+2  signed two's-complement cos result.
sin_val  out  FRAC_W+2  signed two's-complement sin result.
cos_neg / sin_neg  out  1  display sign.
cos_int / sin_int  out  4  BCD integer digit (0 or 1).
cos_frac / sin_frac  out  4*DIGITS  BCD fractional digits, most significant digit in top nibble.

Behaviour:
- Reset: state IDLE. in_ready=1. out_valid=0. All value, sign and digit outputs are 0.
- States: IDLE -> CONV_COS (DIGITS cycles) -> CONV_SIN (DIGITS cycles) -> DONE (1 cycle) -> IDLE.
- in_ready = (state==IDLE).
- Capture happens on a cycle where in_valid && in_ready:
  - Saturate each magnitude above 2^FRAC_W to 2^FRAC_W.
  - If c_s_swap, final cos mag = sin_mag and final sin mag = cos_mag.
  - Latch cos_sign and sin_sign.
  - Latch integer digit = mag[FRAC_W].
  - Latch working remainder = mag[FRAC_W-1:0].
- Each CONV cycle computes p = rem*10 = (rem<<3)+(rem<<1), width FRAC_W+4:
  - Digit = p[FRAC_W+3:FRAC_W], always 0..9.
  - rem <= p[FRAC_W-1:0].
  - Digit is shifted into the frac shift register from the LSB side, so the first digit ends up in the top nibble.
  - Conversion truncates; there is no rounding.
- DONE:
  - Output registers load all results at once.
  - cos_val = sign ? -mag : mag, sign-extended to FRAC_W+2; same for sin_val.
  - out_valid=1 for exactly this cycle.
- Latency: capture at cycle 0, out_valid at cycle 2*DIGITS+1, in_ready high again at cycle 2*DIGITS+2.
- Outputs hold their values until the next DONE.
- in_valid while busy is ignored; no queuing.
- Reset mid-conversion aborts the conversion. No out_valid is produced and all outputs return to their reset values.
- Zero magnitude with sign=1 produces cos_val=0 and cos_neg=1 (negative zero is displayed), unless the optional feature below is enabled.

Optional Feature:
RESULT_NEG_ZERO_CLR_EN
- Defined: at DONE, if a result's integer digit and all fractional digits are 0, its *_neg output is forced to 0. *_val is unaffected (already 0).
- Undefined: *_neg always equals the latched sign flag.

Decomposition:
- Package result_unfold_pkg holds:
  - FRAC_W and DIGITS defaults.
  - State enum (IDLE, CONV_COS, CONV_SIN, DONE).
  - BCD nibble typedef.
  - Constant TEN = 4'd10.
- One sub-module, frac_bcd_step: combinational rem -> {digit, next_rem} multiply-by-10. Instantiated once and shared by both CONV states.

Test Plan:
- cos_mag=0x08000, sin_mag=0x08000, signs 0, swap 0 -> after 9 cycles out_valid pulse; cos/sin = +0.5000, cos_frac=0x5000, cos_val=0x08000.
- cos_mag=0x0DDB4, sin_mag=0x08000, cos_sign=1, swap 0 -> cos_neg=1, cos_int=0, cos_frac=0x8660, cos_val=-0x0DDB4; sin = +0.5000.
- cos_mag=0, sin_mag=0x10000, cos_sign=1, sin_sign=0, swap=1 (180°) -> cos_int=1, cos_frac=0x0000, cos_neg=1, cos_val=-0x10000; sin = 0.0000, sin_neg=0.
- cos_mag=0, sin_mag=0x10000, cos_sign=1, sin_sign=1, swap 0 (270°) -> cos_neg=1 without the macro, cos_neg=0 with it; sin = -1.0000.
- cos_mag=0x10100 -> saturated to cos_int=1, cos_frac=0x0000. Second in_valid at cycle 3 -> ignored, in_ready=0, one out_valid only.
- rst_n low at cycle 4 of a conversion -> no out_valid, all outputs 0, in_ready=1 after release.
